// File: rtl/usb_serial_tx_arbiter.sv
// usb_serial_tx_arbiter
// Round-robin arbiter sharing the usb_serial transmit byte port between
// NUM_REQ byte sources. The winner keeps the grant for a burst so its bytes
// stay contiguous. The burst ends on a last byte, after MAX_BURST bytes, or
// after the owner has held the grant for IDLE_TIMEOUT clocks with no byte
// offered. Output byte and strobe are registered and accepted at most once
// every two clocks, so usb_serial's ready can settle between writes.
module usb_serial_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned MAX_BURST    = 64,
  parameter int unsigned IDLE_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  input  logic                 uart_tx_ready,
  output logic [7:0]           uart_tx_data,
  output logic                 uart_tx_strobe,
  output logic                 busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] w_grant_nxt;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   w_owner_nxt;
  logic [IDX_W-1:0]   r_last_owner;
  logic [IDX_W-1:0]   w_last_owner_nxt;
  logic [IDX_W-1:0]   w_rr_owner;
  logic               w_rr_found;
  int unsigned        w_scan_idx;
  logic [7:0]         r_burst_cnt;
  logic [7:0]         w_burst_cnt_nxt;
  logic [7:0]         r_idle_cnt;
  logic [7:0]         w_idle_cnt_nxt;
  logic [7:0]         r_tx_data;
  logic [7:0]         w_tx_data_nxt;
  logic               r_tx_strobe;
  logic               w_tx_strobe_nxt;
  logic [7:0]         w_owner_byte;
  logic               w_owner_valid;
  logic               w_owner_last;
  logic [7:0]         w_burst_inc;
  logic [7:0]         w_idle_inc;
  logic               w_accept_ok;
  logic               w_handshake;
  logic               w_exit;

  // Select the current owner's byte, valid and last via the one-hot grant.
  always_comb begin
    w_owner_byte  = '0;
    w_owner_valid = 1'b0;
    w_owner_last  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_owner_byte  = req_data[8*i +: 8];
        w_owner_valid = req_valid[i];
        w_owner_last  = req_last[i];
      end
    end
  end

  // Round-robin pick: first valid source scanning upward from last_owner+1.
  always_comb begin
    w_rr_owner = r_last_owner;
    w_rr_found = 1'b0;
    w_scan_idx = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_scan_idx = 32'(r_last_owner) + k;
      if (w_scan_idx >= NUM_REQ) begin
        w_scan_idx = w_scan_idx - NUM_REQ;
      end
      if (!w_rr_found && req_valid[IDX_W'(w_scan_idx)]) begin
        w_rr_found = 1'b1;
        w_rr_owner = IDX_W'(w_scan_idx);
      end
    end
  end

  assign w_burst_inc = r_burst_cnt + 8'd1;
  assign w_idle_inc  = (r_idle_cnt == 8'hFF) ? r_idle_cnt : r_idle_cnt + 8'd1;

  // A pending strobe blocks acceptance so usb_serial's ready reflects the
  // previous write before the next byte is taken.
  assign w_accept_ok = uart_tx_ready & ~r_tx_strobe;
  assign w_handshake = (r_state == ST_BURST) & w_owner_valid & w_accept_ok;

  // grant is all-zero outside a burst, so ready is only ever raised for the owner.
  assign req_ready = r_grant & {NUM_REQ{w_accept_ok}};

  // Next-state, counter and output-register logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    w_burst_cnt_nxt  = r_burst_cnt;
    w_idle_cnt_nxt   = r_idle_cnt;
    w_tx_data_nxt    = r_tx_data;
    w_tx_strobe_nxt  = 1'b0;
    w_exit           = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_rr_found) begin
          w_state_nxt              = ST_BURST;
          w_grant_nxt              = '0;
          w_grant_nxt[w_rr_owner]  = 1'b1;
          w_owner_nxt              = w_rr_owner;
          w_burst_cnt_nxt          = '0;
          w_idle_cnt_nxt           = '0;
        end
      end
      ST_BURST: begin
        if (w_handshake) begin
          w_tx_data_nxt   = w_owner_byte;
          w_tx_strobe_nxt = 1'b1;
          w_burst_cnt_nxt = w_burst_inc;
          w_idle_cnt_nxt  = '0;
        end else if (!w_owner_valid) begin
          w_idle_cnt_nxt  = w_idle_inc;
        end else begin
          w_idle_cnt_nxt  = '0;
        end
        // Exit conditions are OR-ed so coincident causes yield a single exit.
        w_exit = (w_handshake & (w_owner_last | (w_burst_inc == 8'(MAX_BURST))))
               | (~w_owner_valid & (w_idle_inc == 8'(IDLE_TIMEOUT)));
        if (w_exit) begin
          w_state_nxt      = ST_IDLE;
          w_grant_nxt      = '0;
          w_last_owner_nxt = r_owner;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // State and output registers; reset cancels any pending strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_owner      <= '0;
      r_last_owner <= IDX_W'(NUM_REQ - 1);
      r_burst_cnt  <= '0;
      r_idle_cnt   <= '0;
      r_tx_data    <= '0;
      r_tx_strobe  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_burst_cnt  <= w_burst_cnt_nxt;
      r_idle_cnt   <= w_idle_cnt_nxt;
      r_tx_data    <= w_tx_data_nxt;
      r_tx_strobe  <= w_tx_strobe_nxt;
    end
  end

  assign grant          = r_grant;
  assign uart_tx_data   = r_tx_data;
  assign uart_tx_strobe = r_tx_strobe;
  assign busy           = (r_state == ST_BURST);

endmodule

// File: tb/tb_usb_serial_tx_arbiter.sv
// Testbench for usb_serial_tx_arbiter: directed scenarios plus a randomized
// phase, all checked every cycle against a transaction-level model.
module tb_usb_serial_tx_arbiter;

  localparam int N    = 2;
  localparam int MAXB = 64;
  localparam int TMO  = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           uart_tx_ready;
  logic [7:0]     uart_tx_data;
  logic           uart_tx_strobe;
  logic           busy;

  usb_serial_tx_arbiter #(
    .NUM_REQ      (N),
    .MAX_BURST    (MAXB),
    .IDLE_TIMEOUT (TMO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_last       (req_last),
    .req_ready      (req_ready),
    .grant          (grant),
    .uart_tx_ready  (uart_tx_ready),
    .uart_tx_data   (uart_tx_data),
    .uart_tx_strobe (uart_tx_strobe),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Each source is a queue of {last, data} entries; gate masks its valid.
  logic [8:0] srcq [N][$];
  logic [N-1:0] gate;

  // Reference model state.
  bit         m_busy;
  int         m_owner;
  int         m_last;
  int         m_bcnt;
  int         m_icnt;
  bit         m_strobe;
  logic [7:0] m_data;

  // Observation logs for directed literal checks.
  int           log_cyc[$];
  logic [7:0]   log_dat[$];
  logic [N-1:0] glog[$];
  int           idle_grant_cnt;
  int           last_hs_src;
  int           c0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy   = 0;
    m_owner  = 0;
    m_last   = N - 1;
    m_bcnt   = 0;
    m_icnt   = 0;
    m_strobe = 0;
    m_data   = 8'h00;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0) begin
        req_valid[i]      = gate[i];
        req_data[8*i +: 8] = srcq[i][0][7:0];
        req_last[i]       = srcq[i][0][8];
      end else begin
        req_valid[i]      = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]       = 1'b0;
      end
    end
  endtask

  // Advance the model by one clock given the inputs now present.
  task automatic model_update(output int hs_src);
    bit ns;
    bit v;
    bit hs;
    int c;
    hs_src = -1;
    ns     = 0;
    if (!m_busy) begin
      if (|req_valid) begin
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (req_valid[c]) begin
            m_owner = c;
            break;
          end
        end
        m_busy = 1;
        m_bcnt = 0;
        m_icnt = 0;
      end
    end else begin
      v  = req_valid[m_owner];
      hs = v && uart_tx_ready && !m_strobe;
      if (hs) begin
        ns     = 1;
        m_data = req_data[8*m_owner +: 8];
        m_bcnt = m_bcnt + 1;
        m_icnt = 0;
        hs_src = m_owner;
      end else if (!v) begin
        if (m_icnt < 255) m_icnt = m_icnt + 1;
      end else begin
        m_icnt = 0;
      end
      if ((hs && (req_last[m_owner] || m_bcnt == MAXB)) || m_icnt == TMO) begin
        m_busy = 0;
        m_last = m_owner;
      end
    end
    m_strobe = ns;
  endtask

  // One clock: drive inputs, compare at negedge, advance model, return at posedge+1.
  task automatic step();
    logic [N-1:0] eg;
    logic [N-1:0] er;
    int           hs_src;
    drive_inputs();
    @(negedge clk);
    if (!reset) model_reset();
    eg = '0;
    er = '0;
    if (m_busy) eg[m_owner] = 1'b1;
    if (m_busy && uart_tx_ready && !m_strobe) er[m_owner] = 1'b1;
    check("grant",     32'(grant),          32'(eg));
    check("req_ready", 32'(req_ready),      32'(er));
    check("busy",      32'(busy),           32'(m_busy));
    check("strobe",    32'(uart_tx_strobe), 32'(m_strobe));
    check("tx_data",   32'(uart_tx_data),   32'(m_data));
    if (uart_tx_strobe) begin
      log_cyc.push_back(cyc);
      log_dat.push_back(uart_tx_data);
    end
    glog.push_back(grant);
    if (grant == 2'b10 && !req_valid[1]) idle_grant_cnt++;
    if (reset) begin
      model_update(hs_src);
      if (hs_src >= 0) begin
        void'(srcq[hs_src].pop_front());
        last_hs_src = hs_src;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    log_cyc.delete();
    log_dat.delete();
    glog.delete();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b0;
    gate          = '0;
    uart_tx_ready = 1'b1;
    req_valid     = '0;
    req_data      = '0;
    req_last      = '0;
    model_reset();
    run(3);
    check("rst_grant",  32'(grant),          32'h0);
    check("rst_ready",  32'(req_ready),      32'h0);
    check("rst_busy",   32'(busy),           32'h0);
    check("rst_strobe", 32'(uart_tx_strobe), 32'h0);
    check("rst_data",   32'(uart_tx_data),   32'h0);
    reset = 1'b1;

    // 1) Src0 sends A1,A2,A3 with last on A3.
    clear_logs();
    gate = 2'b01;
    srcq[0].push_back({1'b0, 8'hA1});
    srcq[0].push_back({1'b0, 8'hA2});
    srcq[0].push_back({1'b1, 8'hA3});
    c0 = cyc;
    run(10);
    check("t1_nstrobe", 32'(log_dat.size()), 32'd3);
    check("t1_cyc0",    32'(log_cyc[0] - c0), 32'd2);
    check("t1_cyc1",    32'(log_cyc[1] - c0), 32'd4);
    check("t1_cyc2",    32'(log_cyc[2] - c0), 32'd6);
    check("t1_dat0",    32'(log_dat[0]), 32'hA1);
    check("t1_dat1",    32'(log_dat[1]), 32'hA2);
    check("t1_dat2",    32'(log_dat[2]), 32'hA3);
    check("t1_grant1",  32'(glog[1]), 32'h1);
    check("t1_grant5",  32'(glog[5]), 32'h1);
    check("t1_grant6",  32'(glog[6]), 32'h0);

    // 2) Both sources valid straight from reset: src0 first, then alternate.
    reset = 1'b0;
    run(1);
    reset = 1'b1;
    clear_logs();
    gate = 2'b11;
    srcq[0].push_back({1'b0, 8'h10});
    srcq[0].push_back({1'b1, 8'h11});
    srcq[0].push_back({1'b1, 8'h12});
    srcq[1].push_back({1'b1, 8'h20});
    srcq[1].push_back({1'b1, 8'h21});
    run(40);
    check("t2_n",  32'(log_dat.size()), 32'd5);
    check("t2_o0", 32'(log_dat[0]), 32'h10);
    check("t2_o1", 32'(log_dat[1]), 32'h11);
    check("t2_o2", 32'(log_dat[2]), 32'h20);
    check("t2_o3", 32'(log_dat[3]), 32'h12);
    check("t2_o4", 32'(log_dat[4]), 32'h21);

    // 3) Src1 streams 100 bytes without last; src0 waits and cuts in after 64.
    clear_logs();
    for (int k = 0; k < 100; k++) srcq[1].push_back({1'b0, 8'(k)});
    run(3);
    srcq[0].push_back({1'b1, 8'hE0});
    run(400);
    check("t3_n",    32'(log_dat.size()), 32'd101);
    check("t3_b63",  32'(log_dat[63]),  32'd63);
    check("t3_cut",  32'(log_dat[64]),  32'hE0);
    check("t3_b64",  32'(log_dat[65]),  32'd64);
    check("t3_b99",  32'(log_dat[100]), 32'd99);

    // 4) Backpressure for 20 clocks mid-burst: no loss, no duplicate.
    clear_logs();
    gate = 2'b01;
    for (int k = 0; k < 10; k++) srcq[0].push_back({(k == 9) ? 1'b1 : 1'b0, 8'(8'h30 + k)});
    run(5);
    uart_tx_ready = 1'b0;
    run(20);
    uart_tx_ready = 1'b1;
    run(40);
    check("t4_n", 32'(log_dat.size()), 32'd10);
    for (int k = 0; k < 10; k++) check("t4_seq", 32'(log_dat[k]), 32'(8'h30 + k));

    // 5) Owner goes quiet: grant released after IDLE_TIMEOUT idle clocks.
    clear_logs();
    gate = 2'b11;
    idle_grant_cnt = 0;
    srcq[1].push_back({1'b0, 8'h50});
    run(2);
    srcq[0].push_back({1'b1, 8'h60});
    run(40);
    check("t5_idle_clks", 32'(idle_grant_cnt), 32'd16);
    check("t5_n",  32'(log_dat.size()), 32'd2);
    check("t5_d0", 32'(log_dat[0]), 32'h50);
    check("t5_d1", 32'(log_dat[1]), 32'h60);

    // 6) Reset one clock after a handshake cancels the strobe.
    last_hs_src = -1;
    srcq[0].push_back({1'b0, 8'h70});
    srcq[0].push_back({1'b1, 8'h71});
    for (int t = 0; t < 10 && last_hs_src != 0; t++) step();
    check("t6_hs_seen", 32'(last_hs_src), 32'd0);
    reset = 1'b0;
    #1;
    check("t6_strobe_cut", 32'(uart_tx_strobe), 32'h0);
    check("t6_grant_cut",  32'(grant),          32'h0);
    srcq[1].push_back({1'b1, 8'h80});
    run(2);
    reset = 1'b1;
    clear_logs();
    run(30);
    check("t6_n",  32'(log_dat.size()), 32'd2);
    check("t6_d0", 32'(log_dat[0]), 32'h71);
    check("t6_d1", 32'(log_dat[1]), 32'h80);

    // Randomized traffic, backpressure, gating and rare resets.
    for (int t = 0; t < 4000; t++) begin
      gate          = N'($urandom);
      uart_tx_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (srcq[i].size() < 8 && $urandom_range(0, 3) == 0)
          srcq[i].push_back({($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0, 8'($urandom)});
      end
      if ($urandom_range(0, 1499) == 0) reset = 1'b0;
      else reset = 1'b1;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
